seg7_seq_checker: RTL and testbench
===================================

SEG7_SEQ_CHECKER -- requirements
Module: seg7_seq_checker

Interface
REQ-001 Parameter TIMEOUT, default 1000, idle cycles allowed between strobes before a partial match is abandoned; range 2..65535.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 seg_data  input  7  active-low segment pattern, bit6=g ... bit0=a.
REQ-005 seg_valid  input  1  single-cycle strobe qualifying seg_data.
REQ-006 digit  output  4  last successfully decoded BCD digit.
REQ-007 digit_valid  output  1  one-cycle pulse, digit updated.
REQ-008 code_err  output  1  one-cycle pulse, strobed pattern not a legal digit.
REQ-009 match  output  1  one-cycle pulse, full sequence 2,0,0,0,1,1,2,0 completed.
REQ-010 timeout  output  1  one-cycle pulse, partial match abandoned for inactivity.
REQ-011 progress  output  3  current match index, 0..7.
REQ-012 match_cnt  output  8  count of match pulses, wraps 255->0.

Function
REQ-013 Legal patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other pattern is illegal.
REQ-014 All outputs registered; the response to a strobe appears exactly one cycle after the seg_valid cycle.
REQ-015 Legal strobe: digit<=decoded value; digit_valid pulses.
REQ-016 Illegal strobe: code_err pulses; digit and digit_valid unchanged; progress<=0.
REQ-017 Expected digit at index i is SEQ[i] = 2,0,0,0,1,1,2,0.
REQ-018 Legal digit equal to SEQ[progress] and progress<7: progress increments.
REQ-019 Legal digit equal to SEQ[7] at progress=7: match pulses; match_cnt increments; progress<=2 (overlap on suffix "20").
REQ-020 Legal digit not equal to SEQ[progress]: progress<=1 if the digit is 2, else progress<=0.
REQ-021 Idle timer:
  - clears on every strobe and whenever progress=0;
  - otherwise counts once per cycle.
REQ-022 Timer reaching TIMEOUT-1 with no strobe that cycle: timeout pulses; progress<=0; timer clears.
REQ-023 Strobe and timer expiry in the same cycle: the strobe wins; no timeout pulse.
REQ-024 Never more than one of match, code_err, timeout asserted in a cycle; seg_data is ignored when seg_valid=0.

Reset
REQ-025 rst_n low asynchronously clears:
  - digit=0, progress=0, match_cnt=0;
  - all pulses (digit_valid, code_err, match, timeout)=0;
  - the idle timer.
REQ-026 Reset asserted mid-sequence discards the partial match; the first strobe after release is evaluated against SEQ[0].

Structure
REQ-027 Package seg7_pkg holds:
  - the ten segment-pattern constants;
  - the SEQ digit array and its length (8);
  - the overlap restart index (2).
REQ-028 Sub-module seg7_decode is purely combinational: seg_data -> 4-bit BCD plus legal flag. The FSM/timer top instantiates it once.

Verification
REQ-029 Strobe 2,0,0,0,1,1,2,0 on consecutive cycles:
  - match pulses one cycle after the last strobe;
  - match_cnt=1, progress=2.
REQ-030 Continue with 0,0,1,1,2,0 after REQ-029: second match pulse; match_cnt=2 (overlap honoured).
REQ-031 Strobe 2,0,0,2:
  - progress=1 after the final 2;
  - then 0,0,0,1,1,2,0 -> match pulses.
REQ-032 Strobe 2,0, then pattern 1111111: code_err pulses; progress=0; digit stays 0.
REQ-033 TIMEOUT=4; strobe 2, then idle: timeout pulses at the expiry cycle and progress=0. Repeat with a strobe landing on the expiry cycle: no timeout pulse.
REQ-034 Complete 255 matches and then one more: match_cnt wraps to 0. Assert rst_n low mid-sequence: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, target digit sequence and overlap index
package seg7_pkg;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam int SEQ_LEN = 8;
  // Element 0 is the first expected digit: 2,0,0,0,1,1,2,0
  localparam logic [SEQ_LEN-1:0][3:0] SEQ = {4'd0, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2};
  localparam logic [2:0] OVERLAP_IDX = 3'd2;

  function automatic logic [3:0] seq_at(input logic [2:0] idx);
    return SEQ[idx];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 7-segment to BCD decoder with legality flag
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_data,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd   = 4'd0;
    legal = 1'b1;
    case (seg_data)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_seq_checker.sv
// rtl/seg7_seq_checker.sv - decodes strobed segment patterns and tracks the 2,0,0,0,1,1,2,0 sequence
module seg7_seq_checker
  import seg7_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_data,
  input  logic       seg_valid,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       code_err,
  output logic       match,
  output logic       timeout,
  output logic [2:0] progress,
  output logic [7:0] match_cnt
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_IDX   = 3'(SEQ_LEN - 1);

  logic [3:0]  dec_bcd;
  logic        dec_legal;

  logic [3:0]  digit_q, digit_d;
  logic        digit_valid_q, digit_valid_d;
  logic        code_err_q, code_err_d;
  logic        match_q, match_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  progress_q, progress_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [15:0] timer_q, timer_d;

  seg7_decode u_decode (
    .seg_data (seg_data),
    .bcd      (dec_bcd),
    .legal    (dec_legal)
  );

  always_comb begin
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    code_err_d    = 1'b0;
    match_d       = 1'b0;
    timeout_d     = 1'b0;
    progress_d    = progress_q;
    match_cnt_d   = match_cnt_q;
    timer_d       = timer_q;

    // A strobe always takes priority over an expiring idle timer
    if (seg_valid) begin
      timer_d = '0;
      if (!dec_legal) begin
        code_err_d = 1'b1;
        progress_d = 3'd0;
      end else begin
        digit_d       = dec_bcd;
        digit_valid_d = 1'b1;
        if (dec_bcd == seq_at(progress_q)) begin
          if (progress_q == LAST_IDX) begin
            match_d     = 1'b1;
            match_cnt_d = match_cnt_q + 8'd1;
            progress_d  = OVERLAP_IDX;
          end else begin
            progress_d = progress_q + 3'd1;
          end
        end else begin
          // Only a leading 2 can restart a match after a mismatch
          progress_d = (dec_bcd == seq_at(3'd0)) ? 3'd1 : 3'd0;
        end
      end
    end else if (progress_q == 3'd0) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timeout_d  = 1'b1;
      progress_d = 3'd0;
      timer_d    = '0;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      match_q       <= 1'b0;
      timeout_q     <= 1'b0;
      progress_q    <= 3'd0;
      match_cnt_q   <= 8'd0;
      timer_q       <= '0;
    end else begin
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      code_err_q    <= code_err_d;
      match_q       <= match_d;
      timeout_q     <= timeout_d;
      progress_q    <= progress_d;
      match_cnt_q   <= match_cnt_d;
      timer_q       <= timer_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign code_err    = code_err_q;
  assign match       = match_q;
  assign timeout     = timeout_q;
  assign progress    = progress_q;
  assign match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_seg7_seq_checker.sv
// tb/tb_seg7_seq_checker.sv - directed bench for seg7_seq_checker with a digit-history reference model
module tb_seg7_seq_checker;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_data = 7'd0;
  logic       seg_valid = 1'b0;
  logic [3:0] digit;
  logic       digit_valid, code_err, match, timeout;
  logic [2:0] progress;
  logic [7:0] match_cnt;

  seg7_seq_checker #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_data    (seg_data),
    .seg_valid   (seg_valid),
    .digit       (digit),
    .digit_valid (digit_valid),
    .code_err    (code_err),
    .match       (match),
    .timeout     (timeout),
    .progress    (progress),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int SEQ [8] = '{2, 0, 0, 0, 1, 1, 2, 0};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keep the recent legal digits that still form a prefix of the target
  int hist[$];
  int idle = 0;
  int md = 0;
  int m_digit = 0, m_dv = 0, m_ce = 0, m_match = 0, m_to = 0, m_prog = 0, m_cnt = 0;

  function automatic int decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++)
      if (PAT[k] == p) return k;
    return -1;
  endfunction

  function automatic bit tail_is_prefix(input int k);
    if (hist.size() < k) return 1'b0;
    for (int j = 0; j < k; j++)
      if (hist[hist.size() - k + j] != SEQ[j]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      idle = 0;
      m_digit = 0; m_dv = 0; m_ce = 0; m_match = 0; m_to = 0; m_prog = 0; m_cnt = 0;
    end else begin
      m_dv = 0; m_ce = 0; m_match = 0; m_to = 0;
      if (seg_valid) begin
        idle = 0;
        md = decode(seg_data);
        if (md < 0) begin
          m_ce = 1;
          hist.delete();
        end else begin
          m_digit = md;
          m_dv = 1;
          hist.push_back(md);
          if (hist.size() > 8) void'(hist.pop_front());
          if (tail_is_prefix(8)) begin
            m_match = 1;
            m_cnt = (m_cnt + 1) % 256;
          end
          m_prog = 0;
          for (int k = 7; k > 0; k--)
            if (m_prog == 0 && tail_is_prefix(k)) m_prog = k;
          while (hist.size() > m_prog) void'(hist.pop_front());
        end
        m_prog = hist.size();
      end else if (m_prog != 0) begin
        idle++;
        if (idle == TO) begin
          m_to = 1;
          hist.delete();
          m_prog = 0;
          idle = 0;
        end
      end else begin
        idle = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("digit", int'(digit), m_digit);
    chk("digit_valid", int'(digit_valid), m_dv);
    chk("code_err", int'(code_err), m_ce);
    chk("match", int'(match), m_match);
    chk("timeout", int'(timeout), m_to);
    chk("progress", int'(progress), m_prog);
    chk("match_cnt", int'(match_cnt), m_cnt);
    chk("pulse_exclusive", int'((int'(match) + int'(code_err) + int'(timeout)) <= 1), 1);
  end

  task automatic strobe_raw(input logic [6:0] p);
    seg_valid = 1'b1;
    seg_data  = p;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    seg_data  = 7'($urandom);
  endtask

  task automatic strobe(input int d);
    strobe_raw(PAT[d]);
  endtask

  task automatic idle_cycle();
    seg_valid = 1'b0;
    seg_data  = 7'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digit"}, int'(digit), 0);
    chk({tag, "_dv"}, int'(digit_valid), 0);
    chk({tag, "_ce"}, int'(code_err), 0);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_progress"}, int'(progress), 0);
    chk({tag, "_cnt"}, int'(match_cnt), 0);
  endtask

  int full_seq [8] = '{2, 0, 0, 0, 1, 1, 2, 0};
  int tail_seq [6] = '{0, 0, 1, 1, 2, 0};
  logic [6:0] bad_pats [3] = '{7'b1111111, 7'b1010101, 7'b0000001};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle_cycle();

    foreach (full_seq[i]) strobe(full_seq[i]);
    chk("first_match", int'(match), 1);
    chk("first_match_cnt", int'(match_cnt), 1);
    chk("first_match_prog", int'(progress), 2);
    idle_cycle();
    chk("match_one_cycle", int'(match), 0);

    foreach (tail_seq[i]) strobe(tail_seq[i]);
    chk("overlap_match", int'(match), 1);
    chk("overlap_match_cnt", int'(match_cnt), 2);

    strobe(5);
    chk("break_prog", int'(progress), 0);
    chk("break_digit", int'(digit), 5);

    strobe(2); strobe(0); strobe(0); strobe(2);
    chk("restart_prog", int'(progress), 1);
    strobe(0); strobe(0); strobe(0); strobe(1); strobe(1); strobe(2); strobe(0);
    chk("restart_match", int'(match), 1);
    chk("restart_match_cnt", int'(match_cnt), 3);

    strobe(5);
    strobe(2); strobe(0);
    strobe_raw(7'b1111111);
    chk("illegal_ce", int'(code_err), 1);
    chk("illegal_prog", int'(progress), 0);
    chk("illegal_digit", int'(digit), 0);
    chk("illegal_dv", int'(digit_valid), 0);

    for (int d = 0; d < 10; d++) begin
      strobe(d);
      chk("decode_digit", int'(digit), d);
      chk("decode_dv", int'(digit_valid), 1);
    end
    foreach (bad_pats[i]) begin
      strobe_raw(bad_pats[i]);
      chk("bad_pattern_ce", int'(code_err), 1);
    end
    repeat (6) idle_cycle();
    chk("idle_at_zero_no_timeout", int'(timeout), 0);

    strobe(2);
    repeat (3) begin
      idle_cycle();
      chk("pre_expiry_timeout", int'(timeout), 0);
      chk("pre_expiry_prog", int'(progress), 1);
    end
    idle_cycle();
    chk("expiry_timeout", int'(timeout), 1);
    chk("expiry_prog", int'(progress), 0);
    idle_cycle();
    chk("expiry_one_cycle", int'(timeout), 0);

    strobe(2);
    repeat (3) idle_cycle();
    strobe(0);
    chk("strobe_wins_timeout", int'(timeout), 0);
    chk("strobe_wins_prog", int'(progress), 2);
    repeat (4) idle_cycle();
    chk("second_expiry_timeout", int'(timeout), 1);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (full_seq[i]) strobe(full_seq[i]);
    for (int m = 0; m < 254; m++)
      foreach (tail_seq[i]) strobe(tail_seq[i]);
    chk("cnt_255", int'(match_cnt), 255);
    foreach (tail_seq[i]) strobe(tail_seq[i]);
    chk("cnt_wrap_match", int'(match), 1);
    chk("cnt_wrap", int'(match_cnt), 0);

    foreach (tail_seq[i]) strobe(tail_seq[i]);
    chk("post_wrap_cnt", int'(match_cnt), 1);
    strobe(0); strobe(0); strobe(1);
    chk("pre_reset_prog", int'(progress), 5);
    chk("pre_reset_digit", int'(digit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    strobe(0);
    chk("after_reset_prog0", int'(progress), 0);
    chk("after_reset_digit", int'(digit), 0);
    strobe(2);
    chk("after_reset_prog1", int'(progress), 1);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
